// File: rtl/seq_001_tx_pkg.sv
// seq_pkg: shared state encodings and framing constants for the serial transmitter.
package seq_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_PAR  = 2'd3
    } state_t;
    localparam logic [2:0] PRE_BITS = 3'b001;
    localparam int DW_DEF = 8;
endpackage

// File: rtl/seq_001_tx_if.sv
// seq_001_tx_if: word-in / serial-out bundle of the transmitter.
interface seq_001_tx_if import seq_pkg::*; #(parameter int DW = DW_DEF);
    logic [DW-1:0] din;
    logic          valid;
    logic          ready;
    logic          ser_out;
    logic          busy;
    logic          frame_done;
    modport master (output din, valid, input ready, ser_out, busy, frame_done);
    modport slave  (input din, valid, output ready, ser_out, busy, frame_done);
endinterface

// File: rtl/seq_001_tx_shift_reg.sv
// tx_shift_reg: parallel-load, shift-left register exposing its MSB.
module tx_shift_reg #(parameter int DW = 8) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          shift_i,
    input  logic [DW-1:0] d_i,
    output logic          msb_o
);
    logic [DW-1:0] sr_q;
    always_ff @(posedge clk)
        if (rst) sr_q <= '0;
        else if (load_i) sr_q <= d_i;
        else if (shift_i) sr_q <= {sr_q[DW-2:0], 1'b0};
    assign msb_o = sr_q[DW-1];
endmodule

// File: rtl/seq_001_tx.sv
// seq_001_tx: frames each accepted word as preamble, MSB-first payload and even parity.
module seq_001_tx import seq_pkg::*; #(
    parameter int          DW  = DW_DEF,
    parameter logic [2:0]  PRE = PRE_BITS
) (
    input logic         clk,
    input logic         rst,
    seq_001_tx_if.slave bus
);
    // the preamble needs three counter positions even when DW is tiny
    localparam int CW = $clog2(DW) < 2 ? 2 : $clog2(DW);
    localparam logic [CW-1:0] LAST     = CW'(DW - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(2);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ser_q, ser_d, par_q, par_d, load, shift, msb, acc;
    assign bus.ready      = state_q == S_IDLE || state_q == S_PAR;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.frame_done = state_q == S_PAR;
    assign bus.ser_out    = ser_q;
    assign acc            = bus.valid && bus.ready;
    tx_shift_reg #(.DW(DW)) u_sr (
        .clk(clk), .rst(rst), .load_i(load), .shift_i(shift), .d_i(bus.din), .msb_o(msb)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ser_q   <= 1'b1;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            par_q   <= par_d;
        end
    // ser_d is the bit belonging to the next state, so ser_out lines up with state_q
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ser_d   = 1'b1;
        par_d   = par_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE, S_PAR:
                if (acc) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    ser_d   = PRE[2];
                    par_d   = ^bus.din;
                    load    = 1'b1;
                end else state_d = S_IDLE;
            S_PRE:
                if (cnt_q == PRE_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    ser_d   = msb;
                    shift   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    ser_d = cnt_q == '0 ? PRE[1] : PRE[0];
                end
            S_DATA:
                if (cnt_q == LAST) begin
                    state_d = S_PAR;
                    cnt_d   = '0;
                    ser_d   = par_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    ser_d = msb;
                    shift = 1'b1;
                end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_001_tx.sv
// tb_seq_001_tx: directed frames checked cycle by cycle plus a 001-hunting re-framing monitor.
module tb_seq_001_tx;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_frames = 0;
    logic [DW-1:0] exp_q[$];
    seq_001_tx_if #(.DW(DW)) bus ();
    seq_001_tx #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_ser"}, 32'(bus.ser_out), 32'd1);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.frame_done), 32'd0);
    endtask
    // exp holds the 12 line bits, first-sent bit in bit 11
    task automatic run_frame(input logic [7:0] d, input logic [11:0] exp, input bit hold,
                             input int glitch_k, input int rst_k, input string tag);
        bus.din   = d;
        bus.valid = 1'b1;
        if (rst_k < 0) exp_q.push_back(d);
        tick();
        if (!hold) bus.valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("%s_ser%0d", tag, k), 32'(bus.ser_out), 32'(exp[11-k]));
            chk($sformatf("%s_ready%0d", tag, k), 32'(bus.ready), 32'(k == 11));
            chk($sformatf("%s_busy%0d", tag, k), 32'(bus.busy), 32'd1);
            chk($sformatf("%s_done%0d", tag, k), 32'(bus.frame_done), 32'(k == 11));
            if (glitch_k >= 0 && k == glitch_k) begin
                bus.din   = '0;
                bus.valid = 1'b1;
            end
            if (glitch_k >= 0 && k == glitch_k + 1) bus.valid = 1'b0;
            if (k == rst_k) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk_idle({tag, "_rst"});
                tick();
                chk_idle({tag, "_post"});
                return;
            end
            if (k < 11) tick();
        end
    endtask
    // Mealy 001 detector hunts between frames, then collects payload and parity
    int            det = 0;
    int            col = 0;
    logic [DW:0]   sh = '0;
    always @(negedge clk) begin
        if (rst) begin
            det = 0;
            col = 0;
        end else if (col > 0) begin
            sh = {sh[DW-1:0], bus.ser_out};
            col--;
            if (col == 0) begin
                if (exp_q.size() == 0) chk("mon_unexpected", 32'd1, 32'd0);
                else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("mon_payload", 32'(sh[DW:1]), 32'(e));
                    chk("mon_parity", 32'(sh[0]), 32'(^e));
                    n_frames++;
                end
            end
        end else if (det == 2 && bus.ser_out) begin
            det = 0;
            col = DW + 1;
        end else det = bus.ser_out ? 0 : (det == 2 ? 2 : det + 1);
    end
    initial begin
        bus.din   = '0;
        bus.valid = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle($sformatf("idle%0d", i));
        end
        run_frame(8'hA5, 12'h34A, 1'b0, -1, -1, "a5");
        tick();
        chk_idle("a5_end");
        run_frame(8'h01, 12'h203, 1'b1, -1, -1, "b2b1");
        run_frame(8'h01, 12'h203, 1'b0, -1, -1, "b2b2");
        tick();
        chk_idle("b2b_end");
        run_frame(8'hFF, 12'h3FE, 1'b0, 4, -1, "ff");
        tick();
        chk_idle("ff_end");
        tick();
        chk_idle("ff_end2");
        run_frame(8'hC3, 12'h386, 1'b0, -1, 5, "abort");
        run_frame(8'h3C, 12'h278, 1'b0, -1, -1, "clean");
        tick();
        chk_idle("clean_end");
        tick();
        chk("mon_frames", 32'(n_frames), 32'd5);
        chk("mon_queue", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_001_tx.md
SEQ_001_TX -- requirements
Module: seq_001_tx

Interface
REQ-001 Parameter DW, default 8: payload width in bits; legal range 2..16.
REQ-002 Parameter PRE, default 3'b001: preamble, sent MSB first.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  DW  payload word; sampled only on accept.
REQ-006 valid  input  1  source offers din.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 ser_out  output  1  serial line; idles high.
REQ-009 busy  output  1  high while a frame is on the line.
REQ-010 frame_done  output  1  one-cycle pulse marking the last bit of a frame.

Function
REQ-011 Accept SHALL occur on a rising edge where valid && ready; din SHALL be captured into an internal shift register at that edge.
REQ-012 Frame SHALL be: 3 preamble bits (0,0,1), then DW data bits MSB first, then 1 even-parity bit (XOR of all din bits); length DW+4 cycles (12 at DW=8).
REQ-013 FSM states SHALL be IDLE, PRE, DATA, PAR; transitions: IDLE->PRE on accept; PRE->DATA after 3 cycles; DATA->PAR after DW cycles; PAR->PRE on accept, else PAR->IDLE.
REQ-014 ser_out SHALL be registered; the first preamble bit SHALL appear in the cycle after the accept edge (latency 1).
REQ-015 ser_out SHALL be 1 in IDLE.
REQ-016 ready SHALL be high in IDLE and in PAR, and low in PRE and DATA.
REQ-017 busy SHALL be high in PRE, DATA and PAR, and low in IDLE.
REQ-018 frame_done SHALL be high exactly during the PAR cycle.
REQ-019 Back-to-back: an accept in the PAR cycle SHALL start the next preamble in the following cycle, with no idle gap (frame period DW+4).
REQ-020 Changes on din or valid while ready is low SHALL be ignored; the in-flight frame SHALL be unaffected.
REQ-021 A bit counter of width clog2(DW) SHALL count PRE and DATA positions and SHALL reset to 0 on each state entry; no wrap beyond DW-1.
REQ-022 Unreachable state encodings SHALL return to IDLE on the next edge, with ser_out=1.

Reset
REQ-023 While rst is high at an edge, the block SHALL enter IDLE with ser_out=1, ready=1, busy=0, frame_done=0, counter=0 and shift register=0.
REQ-024 rst SHALL take priority over accept.
REQ-025 rst asserted mid-frame SHALL abort the frame; no partial bits SHALL be sent after the reset edge.

Structure
REQ-026 Shared package seq_pkg SHALL hold the state encodings (2-bit), the PRE constant and the default DW.
REQ-027 The FSM, counter and parity logic SHALL reside in seq_001_tx.
REQ-028 One sub-module, tx_shift_reg, SHALL be used: DW-bit parallel-load, shift-left register providing the MSB.

Verification
REQ-029 Reset then idle for 5 cycles -> ser_out=1, ready=1, busy=0, frame_done=0 on every cycle.
REQ-030 din=8'hA5 accepted at edge T -> ser_out from T+1 is 0,0,1,1,0,1,0,0,1,0,1,0 (parity 0); frame_done high only at T+12; ready low T+1..T+11.
REQ-031 din=8'h01 with valid held high continuously -> second frame starts at T+13 with no gap; parity bit 1; period 12 cycles.
REQ-032 Accept 8'hFF, then change din to 8'h00 and pulse valid at T+5 -> frame still carries FF with parity 0; the T+5 word is not accepted.
REQ-033 rst asserted at T+6 of a frame -> ser_out=1, busy=0, ready=1 from the next edge; a new accept afterwards produces a full, clean frame.
REQ-034 Self-check: feed ser_out into a 001 Mealy detector -> it fires on the preamble of every frame; the scoreboard re-frames and matches all payloads and parity bits.
